// File: rtl/qk_pair_issuer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : qk_pair_issuer                                             |
// | Description : Holds a Q bank and a K bank of operand entries and replays |
// |               entries 0..J_eff-1 as registered QK pairs over a           |
// |               valid/ready handshake, pass after pass, until stage 5      |
// |               raises finished or the pass cap is reached.                |
// | Ports       : clk, rst (async, active-low)                               |
// |               start/J_size/max_pass   - job launch, sampled in IDLE      |
// |               wr_valid/wr_ready/wr_sel/wr_addr/wr_data - bank fill       |
// |               QK/qk_valid/qk_ready/qk_idx/pass_end - pair stream         |
// |               finished                - stage-5 termination request      |
// |               pass_cnt/busy/done      - job status                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module qk_pair_issuer #(
  parameter int WIDTH         = 16,
  parameter int parallel_size = 2,
  parameter int para          = 8,
  parameter int DEPTH         = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic [para-1:0]                          J_size,
  input  logic [para-1:0]                          max_pass,
  input  logic                                     wr_valid,
  output logic                                     wr_ready,
  input  logic                                     wr_sel,
  input  logic [$clog2(DEPTH)-1:0]                 wr_addr,
  input  logic [parallel_size*WIDTH-1:0]           wr_data,
  output logic [1:0][parallel_size-1:0][WIDTH-1:0] QK,
  output logic                                     qk_valid,
  input  logic                                     qk_ready,
  output logic [$clog2(DEPTH)-1:0]                 qk_idx,
  output logic                                     pass_end,
  input  logic                                     finished,
  output logic [para-1:0]                          pass_cnt,
  output logic                                     busy,
  output logic                                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = parallel_size * WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    r_state;
  logic [EW-1:0] r_bank_q [DEPTH];
  logic [EW-1:0] r_bank_k [DEPTH];

  logic [AW-1:0]   r_rd_idx;   // next index to load into the output register
  logic [AW-1:0]   r_j_last;   // J_eff - 1 for the running job
  logic [para-1:0] r_max_pass;
  logic [para-1:0] r_pass_cnt;
  logic [2*EW-1:0] r_qk;
  logic            r_qk_valid;
  logic [AW-1:0]   r_qk_idx;
  logic            r_pass_end;
  logic            r_busy;
  logic            r_done;

  logic [para-1:0] w_j_eff;
  logic [AW-1:0]   w_last_start;
  logic [AW-1:0]   w_rd_sel;
  logic [para-1:0] w_cnt_inc;
  logic            w_hs;
  logic            w_cap_hit;
  logic            w_stop;
  logic            w_load;

  assign wr_ready = (r_state == S_IDLE);

  // Banks are not reset; they only change while idle.
  always_ff @(posedge clk) begin
    if (wr_valid && wr_ready) begin
      if (wr_sel) begin
        r_bank_q[wr_addr] <= wr_data;
      end else begin
        r_bank_k[wr_addr] <= wr_data;
      end
    end
  end

  // J_size above DEPTH is clamped so a pass never reads past the bank.
  always_comb begin
    w_j_eff = J_size;
    if (32'(J_size) > 32'(DEPTH)) begin
      w_j_eff = para'(DEPTH);
    end
  end

  assign w_last_start = AW'(w_j_eff - para'(1));

  // The first pair of a job is loaded in the same edge that accepts start.
  assign w_rd_sel  = (r_state == S_IDLE) ? '0 : r_rd_idx;

  assign w_hs      = r_qk_valid && qk_ready;
  assign w_cnt_inc = (r_pass_cnt == '1) ? r_pass_cnt : r_pass_cnt + para'(1);
  assign w_cap_hit = w_hs && r_pass_end && (r_max_pass != '0) &&
                     (w_cnt_inc == r_max_pass);
  assign w_stop    = finished || w_cap_hit;
  assign w_load    = !r_qk_valid || qk_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_rd_idx   <= '0;
      r_j_last   <= '0;
      r_max_pass <= '0;
      r_pass_cnt <= '0;
      r_qk       <= '0;
      r_qk_valid <= 1'b0;
      r_qk_idx   <= '0;
      r_pass_end <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_j_last   <= w_last_start;
            r_max_pass <= max_pass;
            r_pass_cnt <= '0;
            r_busy     <= 1'b1;
            if (w_j_eff == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_ISSUE;
              r_qk       <= {r_bank_q[w_rd_sel], r_bank_k[w_rd_sel]};
              r_qk_valid <= 1'b1;
              r_qk_idx   <= '0;
              r_pass_end <= (w_last_start == '0);
              r_rd_idx   <= (w_last_start == '0) ? '0 : AW'(1);
            end
          end
        end
        S_ISSUE: begin
          if (w_hs && r_pass_end) begin
            r_pass_cnt <= w_cnt_inc;
          end
          // finished and the pass cap share one exit, so only one done pulse.
          if (w_stop) begin
            r_qk_valid <= 1'b0;
            r_state    <= S_DONE;
            r_done     <= 1'b1;
          end else if (w_load) begin
            r_qk       <= {r_bank_q[w_rd_sel], r_bank_k[w_rd_sel]};
            r_qk_valid <= 1'b1;
            r_qk_idx   <= r_rd_idx;
            r_pass_end <= (r_rd_idx == r_j_last);
            r_rd_idx   <= (r_rd_idx == r_j_last) ? '0 : r_rd_idx + AW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_qk_valid <= 1'b0;
        end
      endcase
    end
  end

  assign QK       = r_qk;
  assign qk_valid = r_qk_valid;
  assign qk_idx   = r_qk_idx;
  assign pass_end = r_pass_end;
  assign pass_cnt = r_pass_cnt;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
`default_nettype wire
